// File: rtl/fpnew_pkg.sv
// fpnew_pkg: shared floating-point types for the FPU lane sequencer.
//   fp_format_e  - supported floating-point formats
//   fp_width()   - bit width of a format
//   roundmode_e  - IEEE rounding modes plus dynamic
//   operation_e  - FPU operation codes
//   status_t     - IEEE exception flags {NV, DZ, OF, UF, NX}
package fpnew_pkg;

  typedef enum logic [2:0] {
    FP32    = 3'd0,
    FP64    = 3'd1,
    FP16    = 3'd2,
    FP8     = 3'd3,
    FP16ALT = 3'd4
  } fp_format_e;

  function automatic int unsigned fp_width(fp_format_e fmt);
    case (fmt)
      FP32:    return 32;
      FP64:    return 64;
      FP16:    return 16;
      FP8:     return 8;
      FP16ALT: return 16;
      default: return 32;
    endcase
  endfunction

  typedef enum logic [2:0] {
    RNE = 3'b000,
    RTZ = 3'b001,
    RDN = 3'b010,
    RUP = 3'b011,
    RMM = 3'b100,
    ROD = 3'b101,
    DYN = 3'b111
  } roundmode_e;

  typedef enum logic [3:0] {
    FMADD, FNMSUB, ADD, MUL, DIV, SQRT, SGNJ, MINMAX,
    CMP, CLASSIFY, F2F, F2I, I2F, CPKAB, CPKCD
  } operation_e;

  typedef struct packed {
    logic NV; // invalid operation
    logic DZ; // divide by zero
    logic OF; // overflow
    logic UF; // underflow
    logic NX; // inexact
  } status_t;

endpackage

// File: rtl/fpnew_lane_sequencer.sv
// fpnew_lane_sequencer: runs a vector FP operation on a single-lane unit by
// issuing the lanes one after another and reassembling the lane results into
// one Width-bit word. Scalar operations use lane 0 only.
//
// Ports
//   clk_i, rst_ni, clr_i     clock, async active-low reset, sync clear
//   operands_i ... tag_i     upstream operation (captured on accept)
//   in_valid_i/in_ready_o    upstream handshake
//   flush_i                  abandon any operation in flight
//   unit_*                   single-lane unit request/response interface
//   result_o ... tag_o       reassembled result
//   out_valid_o/out_ready_i  downstream handshake
//   busy_o                   operation in flight or result held
//   state_o                  FSM state (IDLE=0, RUN=1, DONE=2), debug view
//
// Handshakes: a transfer happens on every rising clock edge where valid and
// ready are both high. A valid source holds its payload until the transfer;
// ready may depend on valid, valid never depends on ready.
module fpnew_lane_sequencer
  import fpnew_pkg::*;
#(
  parameter fp_format_e  FpFormat    = FP32,
  parameter int unsigned Width       = 64,
  parameter int unsigned NumOperands = 3,
  parameter type         TagType     = logic
) (
  input  logic                                     clk_i,
  input  logic                                     rst_ni,
  input  logic                                     clr_i,
  // upstream
  input  logic [NumOperands-1:0][Width-1:0]        operands_i,
  input  logic [NumOperands-1:0]                   is_boxed_i,
  input  roundmode_e                               rnd_mode_i,
  input  operation_e                               op_i,
  input  logic                                     op_mod_i,
  input  logic                                     vectorial_op_i,
  input  TagType                                   tag_i,
  input  logic                                     in_valid_i,
  output logic                                     in_ready_o,
  input  logic                                     flush_i,
  // single-lane unit
  output logic [NumOperands-1:0][fp_width(FpFormat)-1:0] unit_operands_o,
  output logic [NumOperands-1:0]                   unit_is_boxed_o,
  output roundmode_e                               unit_rnd_mode_o,
  output operation_e                               unit_op_o,
  output logic                                     unit_op_mod_o,
  output logic                                     unit_in_valid_o,
  input  logic                                     unit_in_ready_i,
  output logic                                     unit_flush_o,
  input  logic [fp_width(FpFormat)-1:0]            unit_result_i,
  input  status_t                                  unit_status_i,
  input  logic                                     unit_ext_bit_i,
  input  logic                                     unit_out_valid_i,
  output logic                                     unit_out_ready_o,
  // downstream
  output logic [Width-1:0]                         result_o,
  output status_t                                  status_o,
  output logic                                     extension_bit_o,
  output TagType                                   tag_o,
  output logic                                     out_valid_o,
  input  logic                                     out_ready_i,
  output logic                                     busy_o,
  output logic [1:0]                               state_o
);

  localparam int unsigned FP_WIDTH  = fp_width(FpFormat);
  localparam int unsigned NUM_LANES = Width / FP_WIDTH;
  localparam int unsigned CW        = $clog2(NUM_LANES + 1);

  typedef logic [CW-1:0] cnt_t;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    RUN  = 2'd1,
    DONE = 2'd2
  } state_e;

  state_e state_q, state_d;

  cnt_t                                     issue_cnt_q, collect_cnt_q, num_lanes_q;
  logic [NumOperands-1:0][Width-1:0]        ops_q;
  logic [NumOperands-1:0]                   boxed_q;
  roundmode_e                               rnd_q;
  operation_e                               op_q;
  logic                                     op_mod_q;
  TagType                                   tag_q;
  logic [NUM_LANES-1:0][FP_WIDTH-1:0]       lane_q;
  status_t                                  status_q;
  logic                                     ext_q;

  logic kill, accept, issue_fire, collect_fire;

  // clear behaves as a flush as far as control is concerned
  assign kill = flush_i | clr_i;

  // ---------------------------------------------------------------------
  // FSM
  // ---------------------------------------------------------------------
  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) state_q <= IDLE;
    else         state_q <= state_d;
  end

  always_comb begin
    state_d          = state_q;
    in_ready_o       = 1'b0;
    out_valid_o      = 1'b0;
    unit_in_valid_o  = 1'b0;
    unit_out_ready_o = 1'b0;
    accept           = 1'b0;
    issue_fire       = 1'b0;
    collect_fire     = 1'b0;
    case (state_q)
      IDLE: begin
        in_ready_o = 1'b1;
        // a flush in the same cycle wins over a new request
        accept     = in_valid_i & ~kill;
        if (accept) state_d = RUN;
      end
      RUN: begin
        unit_in_valid_o  = (issue_cnt_q < num_lanes_q);
        unit_out_ready_o = (collect_cnt_q < num_lanes_q);
        issue_fire       = unit_in_valid_o & unit_in_ready_i;
        collect_fire     = unit_out_ready_o & unit_out_valid_i;
        // leave as soon as the last lane result is written so that a
        // zero-latency unit gives the result two cycles after accept
        if (collect_fire && (collect_cnt_q + cnt_t'(1) == num_lanes_q))
          state_d = DONE;
      end
      DONE: begin
        out_valid_o = 1'b1;
        if (out_ready_i) state_d = IDLE;
      end
      default: state_d = IDLE;
    endcase
    if (kill) state_d = IDLE;
  end

  assign busy_o       = (state_q != IDLE);
  assign unit_flush_o = kill;
  assign state_o      = state_q;

  // ---------------------------------------------------------------------
  // Counters and datapath registers
  // ---------------------------------------------------------------------
  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      issue_cnt_q   <= '0;
      collect_cnt_q <= '0;
      num_lanes_q   <= '0;
      ops_q         <= '0;
      boxed_q       <= '0;
      rnd_q         <= RNE;
      op_q          <= FMADD;
      op_mod_q      <= 1'b0;
      tag_q         <= '0;
      lane_q        <= '0;
      status_q      <= '0;
      ext_q         <= 1'b0;
    end else if (clr_i) begin
      issue_cnt_q   <= '0;
      collect_cnt_q <= '0;
      num_lanes_q   <= '0;
      ops_q         <= '0;
      boxed_q       <= '0;
      rnd_q         <= RNE;
      op_q          <= FMADD;
      op_mod_q      <= 1'b0;
      tag_q         <= '0;
      lane_q        <= '0;
      status_q      <= '0;
      ext_q         <= 1'b0;
    end else if (flush_i) begin
      issue_cnt_q   <= '0;
      collect_cnt_q <= '0;
    end else if (accept) begin
      ops_q         <= operands_i;
      boxed_q       <= is_boxed_i;
      rnd_q         <= rnd_mode_i;
      op_q          <= op_i;
      op_mod_q      <= op_mod_i;
      tag_q         <= tag_i;
      num_lanes_q   <= vectorial_op_i ? cnt_t'(NUM_LANES) : cnt_t'(1);
      issue_cnt_q   <= '0;
      collect_cnt_q <= '0;
      status_q      <= '0;
    end else begin
      if (issue_fire) issue_cnt_q <= issue_cnt_q + cnt_t'(1);
      if (collect_fire) begin
        for (int l = 0; l < NUM_LANES; l++) begin
          if (collect_cnt_q == cnt_t'(l)) lane_q[l] <= unit_result_i;
        end
        status_q      <= status_t'(status_q | unit_status_i);
        if (collect_cnt_q == '0) ext_q <= unit_ext_bit_i;
        collect_cnt_q <= collect_cnt_q + cnt_t'(1);
      end
    end
  end

  // ---------------------------------------------------------------------
  // Unit request: operand slice of the lane currently being issued
  // ---------------------------------------------------------------------
  always_comb begin
    unit_operands_o = '0;
    for (int o = 0; o < NumOperands; o++) begin
      for (int l = 0; l < NUM_LANES; l++) begin
        if (issue_cnt_q == cnt_t'(l))
          unit_operands_o[o] = ops_q[o][l*FP_WIDTH +: FP_WIDTH];
      end
    end
  end

  assign unit_is_boxed_o = boxed_q;
  assign unit_rnd_mode_o = rnd_q;
  assign unit_op_o       = op_q;
  assign unit_op_mod_o   = op_mod_q;

  // ---------------------------------------------------------------------
  // Result assembly: unused lanes and any bits above the last full lane
  // carry lane 0's extension bit (NaN-boxing for scalar results)
  // ---------------------------------------------------------------------
  always_comb begin
    result_o = {Width{ext_q}};
    for (int l = 0; l < NUM_LANES; l++) begin
      if (cnt_t'(l) < num_lanes_q) result_o[l*FP_WIDTH +: FP_WIDTH] = lane_q[l];
      else                         result_o[l*FP_WIDTH +: FP_WIDTH] = {FP_WIDTH{ext_q}};
    end
  end

  assign status_o        = status_q;
  assign extension_bit_o = ext_q;
  assign tag_o           = tag_q;

endmodule

// File: tb/tb_fpnew_lane_sequencer.sv
// Bench for fpnew_lane_sequencer (FP32 lanes, 64-bit word, 3 operands).
// The single-lane unit is modelled as a zero-latency adder: result is a small
// lookup of operand0 + operand1, status is operand 2 bits [4:0], ext bit is 1.
module tb_fpnew_lane_sequencer;
  import fpnew_pkg::*;

  // clock / reset
  logic clk = 1'b0;
  logic rst_n;
  always #5 clk = ~clk;

  logic              clr, flush, in_valid, in_ready, op_mod, vec, tag, tag_out;
  logic [2:0][63:0]  operands;
  logic [2:0]        is_boxed, unit_is_boxed;
  roundmode_e        rnd, unit_rnd;
  operation_e        op, unit_op;
  logic [2:0][31:0]  unit_operands;
  logic              unit_op_mod, unit_in_valid, unit_in_ready, unit_flush;
  logic [31:0]       unit_result;
  status_t           unit_status, status;
  logic              unit_ext, unit_out_valid, unit_out_ready;
  logic [63:0]       result;
  logic              ext, out_valid, out_ready, busy;
  logic [1:0]        state;
  logic              unit_rdy;

  int tests = 0;
  int fails = 0;
  int fire_cnt = 0;
  int out_cnt = 0;

  fpnew_lane_sequencer dut (
    .clk_i(clk), .rst_ni(rst_n), .clr_i(clr),
    .operands_i(operands), .is_boxed_i(is_boxed), .rnd_mode_i(rnd), .op_i(op),
    .op_mod_i(op_mod), .vectorial_op_i(vec), .tag_i(tag), .in_valid_i(in_valid),
    .in_ready_o(in_ready), .flush_i(flush),
    .unit_operands_o(unit_operands), .unit_is_boxed_o(unit_is_boxed),
    .unit_rnd_mode_o(unit_rnd), .unit_op_o(unit_op), .unit_op_mod_o(unit_op_mod),
    .unit_in_valid_o(unit_in_valid), .unit_in_ready_i(unit_in_ready),
    .unit_flush_o(unit_flush), .unit_result_i(unit_result),
    .unit_status_i(unit_status), .unit_ext_bit_i(unit_ext),
    .unit_out_valid_i(unit_out_valid), .unit_out_ready_o(unit_out_ready),
    .result_o(result), .status_o(status), .extension_bit_o(ext), .tag_o(tag_out),
    .out_valid_o(out_valid), .out_ready_i(out_ready), .busy_o(busy), .state_o(state)
  );

  function automatic logic [31:0] add_lut(input logic [31:0] a, input logic [31:0] b);
    case ({a, b})
      {32'h3F800000, 32'h40000000}: return 32'h40400000; // 1+2=3
      {32'h3F800000, 32'h40400000}: return 32'h40800000; // 1+3=4
      {32'h40000000, 32'h40800000}: return 32'h40C00000; // 2+4=6
      {32'h40000000, 32'h40000000}: return 32'h40800000; // 2+2=4
      default:                      return a ^ b;
    endcase
  endfunction

  // zero-latency unit model
  assign unit_in_ready  = unit_rdy;
  assign unit_out_valid = unit_in_valid & unit_rdy;
  assign unit_result    = add_lut(unit_operands[0], unit_operands[1]);
  assign unit_status    = status_t'(unit_operands[2][4:0]);
  assign unit_ext       = 1'b1;

  // handshake counters
  always @(negedge clk) begin
    if (unit_in_valid && unit_in_ready) fire_cnt++;
    if (out_valid && out_ready) out_cnt++;
  end

  initial begin
    #200000;
    $display("FAIL watchdog: simulation time limit reached, expected $finish");
    $fatal(1, "watchdog");
  end

  // ---------------- driver tasks ----------------
  task automatic drive_op(input logic [31:0] a0, input logic [31:0] a1,
                          input logic [31:0] b0, input logic [31:0] b1,
                          input logic [31:0] s0, input logic [31:0] s1,
                          input logic v, input logic t);
    operands[0] = {a1, a0};
    operands[1] = {b1, b0};
    operands[2] = {s1, s0};
    vec = v; tag = t; in_valid = 1'b1;
    @(posedge clk); #1;
    in_valid = 1'b0;
  endtask

  task automatic wait_out(input string name, input int max);
    int n;
    n = 0;
    do begin @(negedge clk); n++; end while (!out_valid && n < max);
    tests++;
    if (!out_valid) begin
      fails++;
      $display("FAIL %s_timeout: out_valid_o=0 after %0d cycles, expected 1", name, max);
    end
  endtask

  // ---------------- scenarios ----------------
  task automatic test_reset();
    #1;
    tests++; if (in_ready !== 1'b1) begin fails++; $display("FAIL reset_in_ready: got %b expected 1", in_ready); end
    tests++; if (out_valid !== 1'b0) begin fails++; $display("FAIL reset_out_valid: got %b expected 0", out_valid); end
    tests++; if (busy !== 1'b0) begin fails++; $display("FAIL reset_busy: got %b expected 0", busy); end
    tests++; if (unit_in_valid !== 1'b0) begin fails++; $display("FAIL reset_unit_in_valid: got %b expected 0", unit_in_valid); end
    tests++; if (unit_out_ready !== 1'b0) begin fails++; $display("FAIL reset_unit_out_ready: got %b expected 0", unit_out_ready); end
    tests++; if (result !== 64'h0) begin fails++; $display("FAIL reset_result: got %h expected 0", result); end
    tests++; if (status !== status_t'(5'b0)) begin fails++; $display("FAIL reset_status: got %b expected 00000", status); end
  endtask

  task automatic test_scalar();
    int f0;
    @(posedge clk); #1;
    unit_rdy = 1'b1; out_ready = 1'b1; f0 = fire_cnt;
    operands[0] = {32'h0, 32'h3F800000};
    operands[1] = {32'h0, 32'h40000000};
    operands[2] = 64'h0;
    vec = 1'b0; tag = 1'b1; in_valid = 1'b1;
    @(negedge clk); // cycle N
    tests++; if (in_ready !== 1'b1) begin fails++; $display("FAIL scalar_accept: in_ready_o=%b expected 1", in_ready); end
    @(posedge clk); #1 in_valid = 1'b0;
    @(negedge clk); // cycle N+1
    tests++; if (out_valid !== 1'b0) begin fails++; $display("FAIL scalar_n1_out_valid: got %b expected 0", out_valid); end
    tests++; if (unit_in_valid !== 1'b1) begin fails++; $display("FAIL scalar_n1_unit_in_valid: got %b expected 1", unit_in_valid); end
    tests++; if (unit_op !== ADD) begin fails++; $display("FAIL scalar_unit_op: got %0d expected %0d", unit_op, ADD); end
    @(negedge clk); // cycle N+2
    tests++; if (out_valid !== 1'b1) begin fails++; $display("FAIL scalar_n2_out_valid: got %b expected 1", out_valid); end
    tests++; if (result !== 64'hFFFFFFFF_40400000) begin fails++; $display("FAIL scalar_result: got %h expected ffffffff40400000", result); end
    tests++; if (status !== status_t'(5'b0)) begin fails++; $display("FAIL scalar_status: got %b expected 00000", status); end
    tests++; if (ext !== 1'b1) begin fails++; $display("FAIL scalar_ext: got %b expected 1", ext); end
    tests++; if (tag_out !== 1'b1) begin fails++; $display("FAIL scalar_tag: got %b expected 1", tag_out); end
    @(posedge clk); #1;
    tests++; if (fire_cnt - f0 !== 1) begin fails++; $display("FAIL scalar_issues: got %0d expected 1", fire_cnt - f0); end
    @(negedge clk);
    tests++; if (busy !== 1'b0) begin fails++; $display("FAIL scalar_back_idle: busy_o=%b expected 0", busy); end
  endtask

  task automatic test_vector();
    int f0, o0;
    @(posedge clk); #1;
    unit_rdy = 1'b1; out_ready = 1'b1; f0 = fire_cnt; o0 = out_cnt;
    drive_op(32'h3F800000, 32'h40000000, 32'h40400000, 32'h40800000, 0, 0, 1'b1, 1'b0);
    wait_out("vector", 10);
    tests++; if (result !== 64'h40C00000_40800000) begin fails++; $display("FAIL vector_result: got %h expected 40c0000040800000", result); end
    tests++; if (tag_out !== 1'b0) begin fails++; $display("FAIL vector_tag: got %b expected 0", tag_out); end
    @(posedge clk); #1;
    tests++; if (fire_cnt - f0 !== 2) begin fails++; $display("FAIL vector_issues: got %0d expected 2", fire_cnt - f0); end
    repeat (3) @(negedge clk);
    @(posedge clk); #1;
    tests++; if (out_cnt - o0 !== 1) begin fails++; $display("FAIL vector_outputs: got %0d expected 1", out_cnt - o0); end
  endtask

  task automatic test_stall();
    int f0, o0;
    @(posedge clk); #1;
    unit_rdy = 1'b0; out_ready = 1'b0; f0 = fire_cnt; o0 = out_cnt;
    drive_op(32'h3F800000, 32'h40000000, 32'h40000000, 32'h40000000, 0, 0, 1'b1, 1'b1);
    for (int i = 0; i < 3; i++) begin
      @(negedge clk);
      tests++; if (unit_in_valid !== 1'b1 || out_valid !== 1'b0) begin fails++; $display("FAIL stall_unit_wait%0d: unit_in_valid_o=%b out_valid_o=%b expected 1/0", i, unit_in_valid, out_valid); end
    end
    @(posedge clk); #1 unit_rdy = 1'b1;
    wait_out("stall", 10);
    tests++; if (result !== 64'h40800000_40400000) begin fails++; $display("FAIL stall_result: got %h expected 4080000040400000", result); end
    for (int i = 0; i < 5; i++) begin
      @(posedge clk); #1;
      @(negedge clk);
      tests++; if (out_valid !== 1'b1 || result !== 64'h40800000_40400000) begin fails++; $display("FAIL stall_hold%0d: out_valid_o=%b result_o=%h expected 1/4080000040400000", i, out_valid, result); end
    end
    @(posedge clk); #1 out_ready = 1'b1;
    @(negedge clk);
    @(posedge clk); #1;
    tests++; if (fire_cnt - f0 !== 2) begin fails++; $display("FAIL stall_issues: got %0d expected 2", fire_cnt - f0); end
    tests++; if (out_cnt - o0 !== 1) begin fails++; $display("FAIL stall_outputs: got %0d expected 1", out_cnt - o0); end
    @(negedge clk);
    tests++; if (out_valid !== 1'b0) begin fails++; $display("FAIL stall_drop_valid: got %b expected 0", out_valid); end
  endtask

  task automatic test_status();
    @(posedge clk); #1;
    unit_rdy = 1'b1; out_ready = 1'b1;
    // lane 0 NX, lane 1 NV
    drive_op(32'h3F800000, 32'h40000000, 32'h40400000, 32'h40800000, 32'h01, 32'h10, 1'b1, 1'b0);
    wait_out("status_vec", 10);
    tests++; if (status !== status_t'(5'b10001)) begin fails++; $display("FAIL status_vector: got %b expected 10001", status); end
    @(posedge clk); #1;
    // scalar: lane 1 flags must not leak in
    drive_op(32'h3F800000, 32'h0, 32'h40000000, 32'h0, 32'h01, 32'h10, 1'b0, 1'b0);
    wait_out("status_scalar", 10);
    tests++; if (status !== status_t'(5'b00001)) begin fails++; $display("FAIL status_scalar: got %b expected 00001", status); end
    tests++; if (result !== 64'hFFFFFFFF_40400000) begin fails++; $display("FAIL status_scalar_result: got %h expected ffffffff40400000", result); end
    @(posedge clk); #1;
  endtask

  task automatic test_flush();
    int f0, o0;
    @(posedge clk); #1;
    unit_rdy = 1'b0; out_ready = 1'b1; f0 = fire_cnt; o0 = out_cnt;
    drive_op(32'h3F800000, 32'h40000000, 32'h40400000, 32'h40800000, 0, 0, 1'b1, 1'b0);
    unit_rdy = 1'b1;
    @(posedge clk); #1;
    unit_rdy = 1'b0; flush = 1'b1;
    @(negedge clk);
    tests++; if (unit_flush !== 1'b1) begin fails++; $display("FAIL flush_unit_flush: got %b expected 1", unit_flush); end
    tests++; if (fire_cnt - f0 !== 1) begin fails++; $display("FAIL flush_lane0_issued: got %0d expected 1", fire_cnt - f0); end
    @(posedge clk); #1 flush = 1'b0;
    @(negedge clk);
    tests++; if (in_ready !== 1'b1 || busy !== 1'b0) begin fails++; $display("FAIL flush_idle: in_ready_o=%b busy_o=%b expected 1/0", in_ready, busy); end
    tests++; if (unit_in_valid !== 1'b0 || unit_flush !== 1'b0) begin fails++; $display("FAIL flush_unit_quiet: unit_in_valid_o=%b unit_flush_o=%b expected 0/0", unit_in_valid, unit_flush); end
    repeat (4) @(negedge clk);
    @(posedge clk); #1;
    tests++; if (out_cnt - o0 !== 0) begin fails++; $display("FAIL flush_no_output: got %0d expected 0", out_cnt - o0); end
    // request coincident with flush is not taken
    in_valid = 1'b1; flush = 1'b1; vec = 1'b0;
    @(posedge clk); #1 in_valid = 1'b0; flush = 1'b0;
    @(negedge clk);
    tests++; if (busy !== 1'b0) begin fails++; $display("FAIL flush_blocks_accept: busy_o=%b expected 0", busy); end
    @(posedge clk); #1 unit_rdy = 1'b1;
    drive_op(32'h3F800000, 32'h0, 32'h40000000, 32'h0, 0, 0, 1'b0, 1'b1);
    wait_out("flush_next", 10);
    tests++; if (result !== 64'hFFFFFFFF_40400000) begin fails++; $display("FAIL flush_next_result: got %h expected ffffffff40400000", result); end
    @(posedge clk); #1;
  endtask

  task automatic test_reset_mid();
    @(posedge clk); #1;
    unit_rdy = 1'b0; out_ready = 1'b1;
    drive_op(32'h3F800000, 32'h40000000, 32'h40400000, 32'h40800000, 32'h01, 0, 1'b1, 1'b1);
    @(negedge clk); #2 rst_n = 1'b0;
    #1;
    tests++; if (busy !== 1'b0 || in_ready !== 1'b1 || out_valid !== 1'b0) begin fails++; $display("FAIL rstmid_ctrl: busy_o=%b in_ready_o=%b out_valid_o=%b expected 0/1/0", busy, in_ready, out_valid); end
    tests++; if (unit_in_valid !== 1'b0 || unit_out_ready !== 1'b0) begin fails++; $display("FAIL rstmid_unit: unit_in_valid_o=%b unit_out_ready_o=%b expected 0/0", unit_in_valid, unit_out_ready); end
    tests++; if (result !== 64'h0 || status !== status_t'(5'b0)) begin fails++; $display("FAIL rstmid_data: result_o=%h status_o=%b expected 0/00000", result, status); end
    @(negedge clk); rst_n = 1'b1; unit_rdy = 1'b1;
    drive_op(32'h3F800000, 32'h40000000, 32'h40400000, 32'h40800000, 0, 0, 1'b1, 1'b0);
    @(negedge clk);
    tests++; if (busy !== 1'b1) begin fails++; $display("FAIL rstmid_first_accept: busy_o=%b expected 1", busy); end
    wait_out("rstmid_next", 10);
    tests++; if (result !== 64'h40C00000_40800000) begin fails++; $display("FAIL rstmid_next_result: got %h expected 40c0000040800000", result); end
    @(posedge clk); #1;
  endtask

  task automatic test_clr();
    @(posedge clk); #1;
    unit_rdy = 1'b1; out_ready = 1'b0;
    drive_op(32'h3F800000, 32'h0, 32'h40000000, 32'h0, 32'h01, 0, 1'b0, 1'b1);
    wait_out("clr", 10);
    @(posedge clk); #1 clr = 1'b1;
    @(negedge clk);
    tests++; if (unit_flush !== 1'b1) begin fails++; $display("FAIL clr_unit_flush: got %b expected 1", unit_flush); end
    @(posedge clk); #1 clr = 1'b0;
    @(negedge clk);
    tests++; if (out_valid !== 1'b0 || in_ready !== 1'b1) begin fails++; $display("FAIL clr_ctrl: out_valid_o=%b in_ready_o=%b expected 0/1", out_valid, in_ready); end
    tests++; if (result !== 64'h0 || status !== status_t'(5'b0) || ext !== 1'b0 || tag_out !== 1'b0) begin fails++; $display("FAIL clr_data: result_o=%h status_o=%b ext=%b tag=%b expected all 0", result, status, ext, tag_out); end
    out_ready = 1'b1;
  endtask

  initial begin
    rst_n = 1'b0; clr = 1'b0; flush = 1'b0; in_valid = 1'b0;
    operands = '0; is_boxed = 3'b111; rnd = RNE; op = ADD; op_mod = 1'b0;
    vec = 1'b0; tag = 1'b0; out_ready = 1'b1; unit_rdy = 1'b1;
    repeat (3) @(posedge clk);
    @(negedge clk); rst_n = 1'b1;
    test_reset();
    test_scalar();
    test_vector();
    test_stall();
    test_status();
    test_flush();
    test_reset_mid();
    test_clr();
    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule

// File: doc/fpnew_lane_sequencer.md
FPNEW_LANE_SEQUENCER -- requirements
Module: fpnew_lane_sequencer

Interface
REQ-001 SHALL have parameters FpFormat (default FP32: format of each lane), Width (default 64: vector word width), NumOperands (default 3: operands per op), TagType (default logic: opaque tag). NUM_LANES = Width/fp_width(FpFormat); FP_WIDTH = fp_width(FpFormat).
REQ-002 SHALL have ports: clk_i in 1 clock; rst_ni in 1 reset (asynchronous, active-low); clr_i in 1 synchronous clear.
REQ-003 SHALL have upstream ports: operands_i in NumOperands x Width; is_boxed_i in NumOperands; rnd_mode_i in roundmode_e; op_i in operation_e; op_mod_i in 1; vectorial_op_i in 1; tag_i in TagType; in_valid_i in 1; in_ready_o out 1; flush_i in 1.
REQ-004 SHALL have unit-side ports: unit_operands_o out NumOperands x FP_WIDTH; unit_is_boxed_o out NumOperands; unit_rnd_mode_o, unit_op_o, unit_op_mod_o out (registered copies); unit_in_valid_o out 1; unit_in_ready_i in 1; unit_flush_o out 1; unit_result_i in FP_WIDTH; unit_status_i in status_t; unit_ext_bit_i in 1; unit_out_valid_i in 1; unit_out_ready_o out 1.
REQ-005 SHALL have downstream ports: result_o out Width; status_o out status_t; extension_bit_o out 1; tag_o out TagType; out_valid_o out 1; out_ready_i in 1; busy_o out 1.

Function
REQ-006 SHALL run a vector op on one single-lane unit by issuing lanes serially and reassembling results into one Width-bit word.
REQ-007 SHALL have FSM states IDLE, RUN, DONE; in_ready_o = (state==IDLE); busy_o = (state!=IDLE).
REQ-008 IDLE: on in_valid_i & in_ready_o, SHALL register operands, is_boxed, rnd_mode, op, op_mod, tag; set L = vectorial_op_i ? NUM_LANES : 1; clear issue/collect counters and status accumulator; go RUN.
REQ-009 RUN: unit_in_valid_o = (issue_cnt < L); unit_operands_o[i] = operand i bits [(issue_cnt+1)*FP_WIDTH-1 : issue_cnt*FP_WIDTH]; issue_cnt increments on unit_in_valid_o & unit_in_ready_i.
REQ-010 RUN: unit_out_ready_o = (collect_cnt < L); on unit_out_valid_i & unit_out_ready_o SHALL write unit_result_i to lane collect_cnt, OR unit_status_i into accumulator, increment collect_cnt; lane 0 result also latches unit_ext_bit_i.
REQ-011 Issue and collect SHALL proceed independently in the same cycle (pipelined unit); results are in order.
REQ-012 RUN -> DONE in the cycle after collect_cnt reaches L; out_valid_o = (state==DONE); DONE -> IDLE on out_ready_i.
REQ-013 result_o: lanes >= L filled with all bits = lane-0 ext bit; bits above NUM_LANES*FP_WIDTH sign-extended with same bit; extension_bit_o = lane-0 ext bit; status_o = OR of L lane statuses; tag_o = captured tag.
REQ-014 Outputs SHALL be stable while out_valid_o & ~out_ready_i.
REQ-015 Scalar op latency with zero-latency unit always ready: accept cycle N, out_valid_o at N+2.
REQ-016 flush_i in any state SHALL force IDLE, clear counters, drop held result, assert unit_flush_o same cycle; flush_i coincident with in_valid_i in IDLE SHALL not accept.
REQ-017 clr_i SHALL act as flush_i plus clearing all datapath registers to 0.
REQ-018 unit_in_valid_o, unit_out_ready_o SHALL be 0 outside RUN.

Reset
REQ-019 On rst_ni low: state IDLE, counters 0, accumulator 0, data registers 0; in_ready_o=1, out_valid_o=0, busy_o=0, unit_in_valid_o=0, unit_out_ready_o=0, result_o=0, status_o=0.
REQ-020 Reset mid-op SHALL abandon the op with no output; first cycle after release accepts new input.

Structure
REQ-021 fp_format_e, fp_width(), roundmode_e, operation_e, status_t SHALL come from fpnew_pkg; FSM state enum SHALL be local.
REQ-022 No sub-modules; counters width $clog2(NUM_LANES+1).

Verification
REQ-023 FP32, Width=64, scalar ADD 1.0+2.0, unit ready -> result_o=0xFFFFFFFF_40400000, status 0, out_valid at N+2.
REQ-024 Vector op, lanes {1.0,2.0}+{3.0,4.0} -> result_o=0x40C00000_40800000, two unit issues, one output.
REQ-025 Unit stalls unit_in_ready_i 3 cycles, out_ready_i low 5 cycles -> no lost/duplicated lane, result held stable.
REQ-026 Lane 1 returns NV, lane 0 NX -> status_o = NV|NX.
REQ-027 flush_i after lane 0 issued -> unit_flush_o pulse, IDLE next cycle, no out_valid_o; next op correct.
REQ-028 rst_ni low mid-RUN -> all outputs at reset values asynchronously; next op correct.
